if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: OUTSTANDING, 2, maximum requests in flight plus responses buffered (power of two, 2..8).
REQ-002 clk  input  1  system clock, all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_i  input  32  fetch address from the PC register.
REQ-005 pc_valid_i  input  1  pc_i is valid.
REQ-006 pc_ready_o  output  1  fetch accepts pc_i this cycle.
REQ-007 flush_i  input  1  redirect (jump taken); kills all older fetches.
REQ-008 req_valid_o  output  1  memory read request valid.
REQ-009 req_addr_o  output  32  word-aligned read address.
REQ-010 req_ready_i  input  1  memory accepts request.
REQ-011 rsp_valid_i  input  1  read data returned (in order, no backpressure).
REQ-012 rsp_data_i  input  32  returned instruction word.
REQ-013 inst_valid_o  output  1  instruction available to decode.
REQ-014 inst_o  output  32  instruction word.
REQ-015 inst_pc_o  output  32  address of inst_o.
REQ-016 inst_ready_i  input  1  decode consumes instruction.

Function
REQ-017 occ = in-flight live + in-flight dropped + buffered entries; occ SHALL never exceed OUTSTANDING.
REQ-018 req_valid_o = pc_valid_i && occ<OUTSTANDING && !flush_i && !rst; pc_ready_o = req_ready_i && occ<OUTSTANDING && !flush_i && !rst (combinational).
REQ-019 req_addr_o = {pc_i[31:2],2'b00}; pc_i[1:0] ignored.
REQ-020 Accept = pc_valid_i && pc_ready_o; on accept pc_i pushed into PC queue, occ+1 next cycle; no slot reuse in the same cycle as a pop.
REQ-021 Each rsp_valid_i (outside flush) with a live in-flight request writes rsp_data_i into the oldest entry lacking data.
REQ-022 rsp_valid_i with zero in-flight requests (live and dropped) SHALL be ignored, no state change.
REQ-023 inst_valid_o high iff oldest queue entry has data; inst_o/inst_pc_o from that entry, driven from registers (no rsp_data_i combinational path).
REQ-024 Minimum latency: accept in cycle N, rsp_valid_i in N+1 -> inst_valid_o in N+2.
REQ-025 Pop on inst_valid_o && inst_ready_i; occ-1 next cycle; push, response and pop in one cycle all honoured.
REQ-026 inst_o/inst_pc_o stable while inst_valid_o && !inst_ready_i.
REQ-027 flush_i: next cycle, all buffered entries discarded, inst_valid_o=0, live in-flight count moved into drop counter; no accept in flush cycle.
REQ-028 rsp_valid_i in the flush cycle counts as dropped (data discarded).
REQ-029 While drop counter>0, each rsp_valid_i decrements it and is discarded; new accepts allowed after flush cycle within REQ-017.
REQ-030 Pop in flush cycle ignored (flush wins); back-to-back flushes each apply REQ-027.
REQ-031 Queue pointers wrap modulo OUTSTANDING; full at occ==OUTSTANDING, empty at occ==0.

Reset
REQ-032 While rst high: pc_ready_o=0, req_valid_o=0, inst_valid_o=0.
REQ-033 After rst: occ=0, drop counter=0, pointers 0, inst_o=0, inst_pc_o=0.
REQ-034 rst mid-operation discards all entries; responses to pre-reset requests are ignored per REQ-022.

Verification
REQ-035 pc_i=0x80000000, memory ready, rsp next cycle 0x00000413 -> inst_valid_o two cycles later, inst_pc_o=0x80000000, inst_o=0x00000413.
REQ-036 Stream 0x80000000,+4,+8 with inst_ready_i=0 -> accepts stop after 2 (pc_ready_o=0), entries held stable; ready=1 drains in order.
REQ-037 Two in flight, flush_i, then pc_i=0x80000100 -> two old responses dropped, only 0x80000100 delivered.
REQ-038 pc_i=0x80000006 -> req_addr_o=0x80000004, inst_pc_o=0x80000006.
REQ-039 Assert rst with 2 entries buffered -> next cycle inst_valid_o=0, stray rsp_valid_i ignored, fresh fetch works.
REQ-040 Random pc/req_ready/rsp delay/inst_ready/flush vs scoreboard; occ never > OUTSTANDING.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues word-aligned reads for incoming PCs,
// buffers in-order responses with their PCs, and presents them to decode.
// A redirect discards buffered entries and turns outstanding reads into drops.
module if_fetch #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  // Queue storage: entries from head_q up to tail_q are live; the oldest
  // pend_q of them lacking data start at wptr_q (responses return in order).
  logic [31:0]      pc_mem_q  [OUTSTANDING];
  logic [31:0]      pc_mem_d  [OUTSTANDING];
  logic [31:0]      dat_mem_q [OUTSTANDING];
  logic [31:0]      dat_mem_d [OUTSTANDING];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W:0]   occ_c;
  logic [CNT_W:0]   inflight_c;
  logic             room_c;
  logic             accept_c;
  logic             pop_c;
  logic             rsp_take_c;

  // Occupancy counts live entries plus reads whose data will be thrown away.
  assign occ_c      = {1'b0, cnt_q} + {1'b0, drop_q};
  assign inflight_c = {1'b0, pend_q} + {1'b0, drop_q};
  assign room_c     = occ_c < (CNT_W + 1)'(OUTSTANDING);

  assign req_valid_o = pc_valid_i  && room_c && !flush_i && !rst;
  assign pc_ready_o  = req_ready_i && room_c && !flush_i && !rst;
  assign req_addr_o  = {pc_i[31:2], 2'b00};
  assign accept_c    = pc_valid_i && pc_ready_o;

  // Head entry has data whenever some live entry is no longer pending.
  assign inst_valid_o = !rst && (cnt_q != pend_q);
  assign inst_o       = dat_mem_q[head_q];
  assign inst_pc_o    = pc_mem_q[head_q];
  assign pop_c        = inst_valid_o && inst_ready_i && !flush_i;
  assign rsp_take_c   = rsp_valid_i && (inflight_c != '0);

  // Next-state for queue pointers, counters and storage.
  always_comb begin
    pc_mem_d  = pc_mem_q;
    dat_mem_d = dat_mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    drop_d    = drop_q;

    if (flush_i) begin
      // Every outstanding read, live or already dropped, becomes a drop.
      head_d = '0;
      tail_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      pend_d = '0;
      drop_d = CNT_W'(inflight_c - (CNT_W + 1)'(rsp_take_c));
    end else begin
      if (rsp_valid_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (pend_q != '0) begin
          dat_mem_d[wptr_q] = rsp_data_i;
          wptr_d = wptr_q + PTR_W'(1);
          pend_d = pend_q - CNT_W'(1);
        end
      end
      if (accept_c) begin
        pc_mem_d[tail_q] = pc_i;
        tail_d = tail_q + PTR_W'(1);
        pend_d = pend_d + CNT_W'(1);
        cnt_d  = cnt_d + CNT_W'(1);
      end
      if (pop_c) begin
        head_d = head_q + PTR_W'(1);
        cnt_d  = cnt_d - CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        pc_mem_q[i]  <= '0;
        dat_mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      pc_mem_q  <= pc_mem_d;
      dat_mem_q <= dat_mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations, then
// randomized traffic against a queue-based model of the fetch buffer.
module tb_if_fetch;

  localparam int unsigned OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  if_fetch #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .pc_ready_o(pc_ready_o), .flush_i(flush_i), .req_valid_o(req_valid_o),
    .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          has;
  } ent_t;

  ent_t        mq[$];
  int          mdrop = 0;
  logic [31:0] memq[$];
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle of inputs, compare against the model, then advance both.
  task automatic step(input bit r, input bit pv, input logic [31:0] pc,
                      input bit fl, input bit rq, input bit rv,
                      input logic [31:0] rd, input bit ir, output bit acc);
    bit   room, exp_iv;
    int   inflight;
    rst = r; pc_valid_i = pv; pc_i = pc; flush_i = fl; req_ready_i = rq;
    rsp_valid_i = rv; rsp_data_i = rd; inst_ready_i = ir;
    #1;
    room   = !r && !fl && (mq.size() + mdrop < OUT);
    exp_iv = !r && mq.size() > 0 && mq[0].has;
    acc    = pv && rq && room;
    chk("req_valid", 32'(req_valid_o), 32'(pv && room));
    chk("pc_ready", 32'(pc_ready_o), 32'(rq && room));
    if (pv && room) chk("req_addr", req_addr_o, pc & 32'hFFFF_FFFC);
    chk("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
    if (exp_iv) begin
      chk("inst", inst_o, mq[0].data);
      chk("inst_pc", inst_pc_o, mq[0].pc);
    end
    if (mq.size() + mdrop > OUT) begin
      checks++;
      $display("FAIL occupancy: got %0d expected at most %0d", mq.size() + mdrop, OUT);
    end
    if (r) begin
      mq.delete();
      mdrop = 0;
    end else if (fl) begin
      inflight = mdrop;
      foreach (mq[i]) if (!mq[i].has) inflight++;
      if (rv && inflight > 0) inflight--;
      mdrop = inflight;
      mq.delete();
    end else begin
      if (rv) begin
        if (mdrop > 0) mdrop--;
        else begin
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].has) begin
              mq[i].data = rd;
              mq[i].has  = 1'b1;
              break;
            end
        end
      end
      if (exp_iv && ir) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, data: 32'h0, has: 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          a;
    bit          r, pv, fl, rq, rv, ir;
    logic [31:0] pc, rd;
    rst = 1'b1; pc_valid_i = 0; pc_i = 0; flush_i = 0; req_ready_i = 0;
    rsp_valid_i = 0; rsp_data_i = 0; inst_ready_i = 0;
    @(posedge clk); #1;

    // Reset state
    step(1, 1, 32'h8000_0000, 0, 1, 0, 0, 0, a);
    chk("rst_iv", 32'(inst_valid_o), 32'h0);
    chk("rst_pcready", 32'(pc_ready_o), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);

    // Single fetch, minimum latency
    step(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, a);
    chk("lat_acc", 32'(a), 32'h1);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0413, 0, a);
    chk("lat_iv", 32'(inst_valid_o), 32'h1);
    chk("lat_pc", inst_pc_o, 32'h8000_0000);
    chk("lat_inst", inst_o, 32'h0000_0413);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);

    // Unaligned PC
    step(0, 1, 32'h8000_0006, 0, 1, 0, 0, 0, a);
    chk("align_addr", req_addr_o, 32'h8000_0004);
    step(0, 0, 0, 0, 0, 1, 32'hCAFE_0001, 0, a);
    chk("align_pc", inst_pc_o, 32'h8000_0006);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);

    // Backpressure: two accepts then stall, hold, drain in order
    step(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, a);
    step(0, 1, 32'h8000_0004, 0, 1, 1, 32'hD000_0000, 0, a);
    step(0, 1, 32'h8000_0008, 0, 1, 1, 32'hD000_0001, 0, a);
    chk("bp_acc3", 32'(a), 32'h0);
    chk("bp_ready", 32'(pc_ready_o), 32'h0);
    step(0, 1, 32'h8000_0008, 0, 1, 0, 0, 0, a);
    chk("bp_hold_pc", inst_pc_o, 32'h8000_0000);
    chk("bp_hold_inst", inst_o, 32'hD000_0000);
    step(0, 1, 32'h8000_0008, 0, 1, 0, 0, 1, a);
    chk("bp_drain1", inst_pc_o, 32'h8000_0004);
    step(0, 1, 32'h8000_0008, 0, 1, 0, 0, 1, a);
    chk("bp_acc_after", 32'(a), 32'h1);
    chk("bp_empty", 32'(inst_valid_o), 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'hD000_0002, 1, a);
    chk("bp_drain3", inst_pc_o, 32'h8000_0008);
    chk("bp_drain3_inst", inst_o, 32'hD000_0002);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);

    // Flush with two in flight
    step(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, a);
    step(0, 1, 32'h8000_0004, 0, 1, 0, 0, 0, a);
    step(0, 1, 32'h8000_0010, 1, 1, 0, 0, 0, a);
    chk("fl_noacc", 32'(a), 32'h0);
    step(0, 1, 32'h8000_0100, 0, 1, 1, 32'hBAD0_0000, 0, a);
    chk("fl_full", 32'(a), 32'h0);
    step(0, 1, 32'h8000_0100, 0, 1, 1, 32'hBAD0_0001, 0, a);
    chk("fl_acc", 32'(a), 32'h1);
    chk("fl_iv0", 32'(inst_valid_o), 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h1111_1111, 0, a);
    chk("fl_pc", inst_pc_o, 32'h8000_0100);
    chk("fl_inst", inst_o, 32'h1111_1111);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);

    // Reset with two buffered entries
    step(0, 1, 32'h8000_0000, 0, 1, 0, 0, 0, a);
    step(0, 1, 32'h8000_0004, 0, 1, 1, 32'h0000_00AA, 0, a);
    step(0, 0, 0, 0, 0, 1, 32'h0000_00BB, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, 0, a);
    chk("mr_iv", 32'(inst_valid_o), 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, a);
    chk("mr_stray", 32'(inst_valid_o), 32'h0);
    step(0, 1, 32'h8000_0200, 0, 1, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 1, 32'h2222_2222, 0, a);
    chk("mr_pc", inst_pc_o, 32'h8000_0200);
    chk("mr_inst", inst_o, 32'h2222_2222);
    step(0, 0, 0, 0, 0, 0, 0, 1, a);

    // Randomized traffic with an in-order memory
    step(1, 0, 0, 0, 0, 0, 0, 0, a);
    memq.delete();
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 19) == 0);
      pv = ($urandom_range(0, 9) < 7);
      rq = ($urandom_range(0, 9) < 7);
      ir = ($urandom_range(0, 9) < 6);
      pc = $urandom;
      rd = $urandom;
      if (memq.size() > 0) rv = ($urandom_range(0, 1) == 1);
      else                 rv = ($urandom_range(0, 31) == 0);
      if (rv && memq.size() > 0) void'(memq.pop_front());
      step(r, pv, pc, fl, rq, rv, rd, ir, a);
      if (r) memq.delete();
      else if (a) memq.push_back(pc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
